// File: rtl/perf_monitor_pkg.sv
// perf_monitor_pkg: FSM state type, read-port indices, signature seed and MISR step
package perf_monitor_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int REG_CYC  = 0;
    localparam int REG_RET  = 1;
    localparam int REG_SIG  = 2;
    localparam int REG_STAT = 3;
    localparam int REG_EVT0 = 4;
    localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;
    function automatic logic [31:0] misr_next(input logic [31:0] sig, input logic [31:0] din);
        return {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ din;
    endfunction
endpackage

// File: rtl/perf_monitor_if.sv
// perf_monitor_if: core/event/read-port bundle between the bench or SoC and the monitor
interface perf_monitor_if #(parameter int NUM_CH = 4);
    logic              start;
    logic              stop;
    logic              pc_en;
    logic [31:0]       wb_result;
    logic [NUM_CH-1:0] evt;
    logic [3:0]        rd_sel;
    logic [31:0]       rd_data;
    logic              done;
    logic              led;
    modport master (output start, stop, pc_en, wb_result, evt, rd_sel, input rd_data, done, led);
    modport slave  (input start, stop, pc_en, wb_result, evt, rd_sel, output rd_data, done, led);
endinterface

// File: rtl/perf_counter.sv
// perf_counter: saturating counter with sticky overflow set by an increment attempted at all-ones
module perf_counter #(parameter int CNT_W = 32) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (&value) ovf <= 1'b1;
            else value <= value + CNT_W'(1);
        end
    end
endmodule

// File: rtl/perf_monitor.sv
// perf_monitor: benchmark cycle/retire/event counter with registered read port; PERF_MONITOR_SIG_EN adds a write-back MISR
module perf_monitor
    import perf_monitor_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 256
) (
    input  logic           clk,
    input  logic           rst,
    perf_monitor_if.slave  bus
);
    localparam int N  = NUM_CH + 2;
    localparam int SW = $clog2(STALL_LIMIT + 1);
    state_t           state, state_next;
    logic [SW-1:0]    stall;
    logic             clr, inc_en, stall_hit;
    logic [N-1:0]     inc, ovf;
    logic [CNT_W-1:0] cnt [N];
    logic [7:0]       ovf_evt;
    logic [31:0]      sig, rd_next;
    // stop beats a simultaneous start while running; elsewhere start always restarts
    assign clr       = bus.start && !(state == RUN && bus.stop);
    assign inc_en    = state == RUN && !clr;
    assign stall_hit = !bus.pc_en && stall == SW'(STALL_LIMIT - 1);
    assign inc       = {bus.evt, bus.pc_en, 1'b1} & {N{inc_en}};
    for (genvar g = 0; g < N; g++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk, .rst, .clr, .inc(inc[g]), .value(cnt[g]), .ovf(ovf[g])
        );
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_next;
    always_comb begin
        state_next = state == IDLE ? (bus.start ? RUN : IDLE)
                   : state == RUN  ? (bus.stop ? DONE : bus.start ? RUN : stall_hit ? DONE : RUN)
                   : (bus.start ? RUN : DONE);
    end
    always_comb begin
        bus.done = state == DONE;
        bus.led  = state == DONE;
    end
    always_ff @(posedge clk) begin
        if (rst || clr) stall <= '0;
        else if (state == RUN) stall <= bus.pc_en ? '0 : stall + SW'(1);
    end
`ifdef PERF_MONITOR_SIG_EN
    always_ff @(posedge clk) begin
        if (rst) sig <= '0;
        else if (clr) sig <= SIG_SEED;
        else if (inc_en && bus.pc_en) sig <= misr_next(sig, bus.wb_result);
    end
`else
    logic unused_wb;
    assign unused_wb = ^bus.wb_result;
    assign sig = '0;
`endif
    always_comb begin
        ovf_evt = '0;
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ovf_evt[i] = ovf[i+2];
            if (int'(bus.rd_sel) == REG_EVT0 + i) rd_next = 32'(cnt[i+2]);
        end
        rd_next = int'(bus.rd_sel) == REG_CYC  ? 32'(cnt[0])
                : int'(bus.rd_sel) == REG_RET  ? 32'(cnt[1])
                : int'(bus.rd_sel) == REG_SIG  ? sig
                : int'(bus.rd_sel) == REG_STAT ? {16'b0, ovf_evt, ovf[1], ovf[0], 4'b0, state}
                : rd_next;
    end
    always_ff @(posedge clk) bus.rd_data <= rst ? '0 : rd_next;
endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: randomized self-checking bench with a cycle-level behavioural model of the monitor
module tb_perf_monitor;
    localparam int NUM_CH = 4;
    localparam int CNT_W = 16;
    localparam int STALL_LIMIT = 8;
    localparam int MAXC = (1 << CNT_W) - 1;
    logic clk = 1'b0;
    logic rst;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    perf_monitor_if #(.NUM_CH(NUM_CH)) bus ();
    perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        logic fb;
        fb = s[31] ^ s[21] ^ s[1] ^ s[0];
        return ((s << 1) | {31'b0, fb}) ^ d;
    endfunction
    function automatic logic [31:0] sig_exp(input logic [31:0] model);
`ifdef PERF_MONITOR_SIG_EN
        return model;
`else
        return model & 32'h0;
`endif
    endfunction
    function automatic logic [31:0] sat(input int v);
        return 32'(v > MAXC ? MAXC : v);
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle_inputs();
        bus.start = 0; bus.stop = 0; bus.pc_en = 0; bus.wb_result = 0; bus.evt = 0;
    endtask
    task automatic rd(input int s, output logic [31:0] v);
        bus.rd_sel = 4'(s);
        step();
        v = bus.rd_data;
    endtask
    task automatic pulse_start();
        bus.start = 1;
        step();
        bus.start = 0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        idle_inputs();
        bus.rd_sel = 0;
        rst = 1;
        step(); step();
        rst = 0;
        repeat (10) step();
        for (int s = 0; s < 8; s++) begin
            rd(s, v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset rd_sel=%0d got=%h exp=0", s, v); end
        end
        checks++;
        if (bus.done !== 1'b0 || bus.led !== 1'b0) begin
            errors++; $display("FAIL reset done/led got=%b/%b exp=0/0", bus.done, bus.led);
        end
    endtask

    task automatic test_run_stop();
        logic [31:0] v, msig;
        logic [31:0] exp [5];
        msig = 32'hFFFF_FFFF;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            bus.pc_en = (k % 2 == 0);
            bus.wb_result = $urandom;
            if (bus.pc_en) msig = misr(msig, bus.wb_result);
            step();
        end
        bus.pc_en = 0; bus.stop = 1;
        step();
        bus.stop = 0;
        checks++;
        if (bus.done !== 1'b1 || bus.led !== 1'b1) begin
            errors++; $display("FAIL run_stop done/led got=%b/%b exp=1/1", bus.done, bus.led);
        end
        exp = '{32'd21, 32'd10, sig_exp(msig), 32'd2, 32'd0};
        for (int s = 0; s < 5; s++) begin
            rd(s, v);
            checks++;
            if (v !== exp[s]) begin errors++; $display("FAIL run_stop rd_sel=%0d got=%h exp=%h", s, v, exp[s]); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] v;
        int n;
        idle_inputs();
        pulse_start();
        n = 0;
        while (!bus.done && n < 50) begin step(); n++; end
        checks++;
        if (n != 8) begin errors++; $display("FAIL stall run_cycles got=%0d exp=8", n); end
        rd(0, v);
        checks++;
        if (v !== 32'd8) begin errors++; $display("FAIL stall cyc got=%h exp=%h", v, 32'd8); end
        rd(3, v);
        checks++;
        if (v !== 32'd2) begin errors++; $display("FAIL stall status got=%h exp=%h", v, 32'd2); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        idle_inputs();
        pulse_start();
        bus.pc_en = 1; bus.evt = 4'b0001;
        repeat (70000) step();
        bus.evt = 0; bus.pc_en = 0; bus.stop = 1;
        step();
        bus.stop = 0;
        rd(4, v);
        checks++;
        if (v !== 32'h0000_FFFF) begin errors++; $display("FAIL ovf evt0 got=%h exp=0000ffff", v); end
        rd(5, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL ovf evt1 got=%h exp=0", v); end
        rd(3, v);
        checks++;
        if (v !== 32'h0000_01C2) begin errors++; $display("FAIL ovf status got=%h exp=000001c2", v); end
        pulse_start();
        bus.stop = 1;
        step();
        bus.stop = 0;
        rd(4, v);
        checks++;
        if (v !== 32'h0) begin errors++; $display("FAIL ovf_clear evt0 got=%h exp=0", v); end
        rd(3, v);
        checks++;
        if (v !== 32'h2) begin errors++; $display("FAIL ovf_clear status got=%h exp=2", v); end
        rd(0, v);
        checks++;
        if (v !== 32'h1) begin errors++; $display("FAIL ovf_clear cyc got=%h exp=1", v); end
    endtask

    task automatic test_random();
        logic [31:0] v, msig;
        logic [31:0] exp [8];
        int cyc, ret, zeros;
        int ev [NUM_CH];
        bit running;
        for (int it = 0; it < 3; it++) begin
            idle_inputs();
            pulse_start();
            cyc = 0; ret = 0; zeros = 0; running = 1; msig = 32'hFFFF_FFFF;
            for (int c = 0; c < NUM_CH; c++) ev[c] = 0;
            for (int k = 0; k < 300; k++) begin
                bus.pc_en = ($urandom_range(0, 3) != 0);
                bus.evt = 4'($urandom);
                bus.wb_result = $urandom;
                if (running) begin
                    cyc++;
                    ret += int'(bus.pc_en);
                    for (int c = 0; c < NUM_CH; c++) ev[c] += int'(bus.evt[c]);
                    if (bus.pc_en) msig = misr(msig, bus.wb_result);
                    zeros = bus.pc_en ? 0 : zeros + 1;
                    if (zeros == STALL_LIMIT) running = 0;
                end
                step();
            end
            bus.pc_en = 0; bus.evt = 0; bus.stop = 1;
            if (running) cyc++;
            step();
            bus.stop = 0;
            checks++;
            if (bus.done !== 1'b1) begin errors++; $display("FAIL random[%0d] done got=%b exp=1", it, bus.done); end
            exp[0] = sat(cyc); exp[1] = sat(ret); exp[2] = sig_exp(msig); exp[3] = 32'd2;
            for (int c = 0; c < NUM_CH; c++) exp[4+c] = sat(ev[c]);
            for (int s = 0; s < 8; s++) begin
                rd(s, v);
                checks++;
                if (v !== exp[s]) begin errors++; $display("FAIL random[%0d] rd_sel=%0d got=%h exp=%h", it, s, v, exp[s]); end
            end
        end
    endtask

    task automatic test_start_stop();
        logic [31:0] v;
        idle_inputs();
        pulse_start();
        bus.pc_en = 1;
        repeat (5) step();
        bus.start = 1; bus.stop = 1;
        step();
        bus.start = 0; bus.stop = 0;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL start_stop done got=%b exp=1", bus.done); end
        rd(0, v);
        checks++;
        if (v !== 32'd6) begin errors++; $display("FAIL start_stop cyc got=%h exp=%h", v, 32'd6); end
        pulse_start();
        repeat (5) step();
        bus.start = 1;
        step();
        bus.start = 0;
        repeat (3) step();
        bus.stop = 1;
        step();
        bus.stop = 0;
        rd(0, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL restart cyc got=%h exp=%h", v, 32'd4); end
        rd(1, v);
        checks++;
        if (v !== 32'd4) begin errors++; $display("FAIL restart ret got=%h exp=%h", v, 32'd4); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        idle_inputs();
        pulse_start();
        bus.pc_en = 1; bus.evt = 4'hF;
        repeat (10) step();
        rst = 1; bus.start = 1;
        step();
        rst = 0;
        idle_inputs();
        checks++;
        if (bus.done !== 1'b0 || bus.led !== 1'b0) begin
            errors++; $display("FAIL reset_mid done/led got=%b/%b exp=0/0", bus.done, bus.led);
        end
        for (int s = 0; s < 8; s++) begin
            rd(s, v);
            checks++;
            if (v !== 32'h0) begin errors++; $display("FAIL reset_mid rd_sel=%0d got=%h exp=0", s, v); end
        end
    endtask

    initial begin
        test_reset();
        test_run_stop();
        test_stall();
        test_overflow();
        test_random();
        test_start_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
